// File: rtl/md5_pkg.sv
// Shared MD5 padder types: block word layout, padder FSM states and padding constants.
package md5_pkg;

  typedef logic [31:0] word_t;
  typedef word_t [0:15] block_t;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StPad80,
    StZero,
    StLen,
    StEmit
  } pad_state_e;

  localparam int unsigned MD5_BLK_BYTES = 64;
  localparam int unsigned MD5_LEN_OFS   = 56;
  localparam logic [7:0]  MD5_PAD_BYTE  = 8'h80;

endpackage

// File: rtl/md5_byte_packer.sv
// Single 512-bit block buffer: byte writes land little-endian at a byte offset, the
// length write fills M[14]/M[15] in one cycle, and clear zeroes the whole buffer.
module md5_byte_packer
  import md5_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clr,
  input  logic        i_we,
  input  logic [5:0]  i_ofs,
  input  logic [7:0]  i_byte,
  input  logic        i_len_we,
  input  logic [63:0] i_len,
  output block_t      o_blk
);

  block_t r_blk;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_blk <= '0;
    end else if (i_clr) begin
      r_blk <= '0;
    end else begin
      // Byte 4k+j of the block sits in bits [8j+7:8j] of word k.
      if (i_we) r_blk[i_ofs[5:2]][{i_ofs[1:0], 3'b000} +: 8] <= i_byte;
      if (i_len_we) begin
        r_blk[14] <= i_len[31:0];
        r_blk[15] <= i_len[63:32];
      end
    end
  end

  assign o_blk = r_blk;

endmodule

// File: rtl/md5_msg_padder.sv
// MD5 message padder: packs a byte stream into 512-bit blocks with 0x80/zero/length padding.
// Define MD5_PAD_LEN_OUT_EN to expose the final message bit length on msg_bits_o.
module md5_msg_padder
  import md5_pkg::*;
#(
  parameter int unsigned N     = 32,
  parameter int unsigned LEN_W = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [7:0]           byte_i,
  input  logic                 byte_valid_i,
  input  logic                 byte_last_i,
  input  logic                 byte_empty_i,
  output logic                 byte_ready_o,
  output logic [0:15][N-1:0]   blk_o,
  output logic                 blk_valid_o,
  output logic                 blk_last_o,
  input  logic                 blk_ready_i,
  output logic                 busy_o
`ifdef MD5_PAD_LEN_OUT_EN
  ,
  output logic [LEN_W-1:0]     msg_bits_o
`endif
);

  pad_state_e       r_state, w_state_d, r_ret, w_ret_d;
  logic [5:0]       r_ofs, w_ofs_d, w_ofs_inc;
  logic [LEN_W-1:0] r_bitlen, w_bitlen_d;
  logic             r_fill, w_fill_d;
  logic             r_valid, w_valid_d;
  logic             r_last, w_last_d;
  logic             w_accept, w_we, w_len_we, w_clr;
  logic [7:0]       w_data;
  block_t           w_blk;

  assign byte_ready_o = (r_state == StIdle || r_state == StLoad) && !r_valid;
  assign w_accept     = byte_valid_i && byte_ready_o;
  assign w_ofs_inc    = r_ofs + 6'd1;

  always_comb begin
    w_state_d  = r_state;
    w_ret_d    = r_ret;
    w_ofs_d    = r_ofs;
    w_bitlen_d = r_bitlen;
    w_fill_d   = r_fill;
    w_valid_d  = r_valid;
    w_last_d   = r_last;
    w_we       = 1'b0;
    w_data     = byte_i;
    w_len_we   = 1'b0;
    w_clr      = 1'b0;
    unique case (r_state)
      StIdle, StLoad: begin
        if (w_accept) begin
          if (byte_last_i && byte_empty_i) begin
            w_state_d = StPad80;
          end else begin
            w_we       = 1'b1;
            w_ofs_d    = w_ofs_inc;
            w_bitlen_d = r_bitlen + LEN_W'(8);
            if (r_ofs == 6'(MD5_BLK_BYTES - 1)) begin
              // Full block: emit it first, padding resumes afterwards if this was the last byte.
              w_state_d = StEmit;
              w_valid_d = 1'b1;
              w_last_d  = 1'b0;
              w_ret_d   = byte_last_i ? StPad80 : StLoad;
            end else begin
              w_state_d = byte_last_i ? StPad80 : StLoad;
            end
          end
        end
      end
      StPad80: begin
        w_we    = 1'b1;
        w_data  = MD5_PAD_BYTE;
        w_ofs_d = w_ofs_inc;
        if (w_ofs_inc == 6'd0) begin
          w_state_d = StEmit;
          w_valid_d = 1'b1;
          w_last_d  = 1'b0;
          w_ret_d   = StZero;
        end else if (w_ofs_inc > 6'(MD5_LEN_OFS)) begin
          w_state_d = StZero;
          w_fill_d  = 1'b1;
        end else if (w_ofs_inc == 6'(MD5_LEN_OFS)) begin
          w_state_d = StLen;
        end else begin
          w_state_d = StZero;
        end
      end
      StZero: begin
        w_we    = 1'b1;
        w_data  = 8'h00;
        w_ofs_d = w_ofs_inc;
        if (r_fill) begin
          if (r_ofs == 6'(MD5_BLK_BYTES - 1)) begin
            w_state_d = StEmit;
            w_valid_d = 1'b1;
            w_last_d  = 1'b0;
            w_ret_d   = StZero;
            w_fill_d  = 1'b0;
          end
        end else if (r_ofs == 6'(MD5_LEN_OFS - 1)) begin
          w_state_d = StLen;
        end
      end
      StLen: begin
        w_len_we  = 1'b1;
        w_state_d = StEmit;
        w_valid_d = 1'b1;
        w_last_d  = 1'b1;
      end
      StEmit: begin
        if (blk_ready_i) begin
          w_clr     = 1'b1;
          w_valid_d = 1'b0;
          w_last_d  = 1'b0;
          if (r_last) begin
            w_bitlen_d = '0;
            w_ofs_d    = '0;
            w_state_d  = StIdle;
          end else begin
            w_state_d = r_ret;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= StIdle;
      r_ret    <= StLoad;
      r_ofs    <= '0;
      r_bitlen <= '0;
      r_fill   <= 1'b0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_ret    <= w_ret_d;
      r_ofs    <= w_ofs_d;
      r_bitlen <= w_bitlen_d;
      r_fill   <= w_fill_d;
      r_valid  <= w_valid_d;
      r_last   <= w_last_d;
    end
  end

  md5_byte_packer u_packer (
    .i_clk    (clk_i),
    .i_rst    (rst_i),
    .i_clr    (w_clr),
    .i_we     (w_we),
    .i_ofs    (r_ofs),
    .i_byte   (w_data),
    .i_len_we (w_len_we),
    .i_len    (64'(r_bitlen)),
    .o_blk    (w_blk)
  );

  assign blk_o       = w_blk;
  assign blk_valid_o = r_valid;
  assign blk_last_o  = r_last;
  assign busy_o      = (r_state != StIdle);

`ifdef MD5_PAD_LEN_OUT_EN
  logic [LEN_W-1:0] r_msg_bits;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_msg_bits <= '0;
    end else if (w_len_we) begin
      r_msg_bits <= r_bitlen;
    end else if (w_clr && r_last) begin
      r_msg_bits <= '0;
    end
  end

  assign msg_bits_o = r_msg_bits;
`endif

endmodule

// File: tb/tb_md5_msg_padder.sv
// Directed bench for md5_msg_padder: known messages with hand-computed padded blocks.
module tb_md5_msg_padder;
  import md5_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [7:0] byte_i;
  logic       byte_valid_i, byte_last_i, byte_empty_i, byte_ready_o;
  block_t     blk_o;
  logic       blk_valid_o, blk_last_o, blk_ready_i, busy_o;
`ifdef MD5_PAD_LEN_OUT_EN
  logic [63:0] msg_bits_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  block_t rx_blk;
  logic   rx_last;

  always #5 clk_i = ~clk_i;

  md5_msg_padder dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .byte_last_i  (byte_last_i),
    .byte_empty_i (byte_empty_i),
    .byte_ready_o (byte_ready_o),
    .blk_o        (blk_o),
    .blk_valid_o  (blk_valid_o),
    .blk_last_o   (blk_last_o),
    .blk_ready_i  (blk_ready_i),
    .busy_o       (busy_o)
`ifdef MD5_PAD_LEN_OUT_EN
    ,
    .msg_bits_o   (msg_bits_o)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last, input logic empty);
    int n = 0;
    @(negedge clk_i);
    byte_i       = b;
    byte_valid_i = 1'b1;
    byte_last_i  = last;
    byte_empty_i = empty;
    while (!byte_ready_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 200) check_eq("byte_ready_timeout", 64'(byte_ready_o), 64'd1);
    @(posedge clk_i);
    #1;
    byte_valid_i = 1'b0;
    byte_last_i  = 1'b0;
    byte_empty_i = 1'b0;
  endtask

  task automatic send_run(input int cnt, input logic [7:0] b, input logic last);
    for (int i = 0; i < cnt; i++) send_byte(b, last && (i == cnt - 1), 1'b0);
  endtask

  // Waits for a block, holds blk_ready_i low for 'hold' cycles checking stability, then takes it.
  task automatic recv_block(input int hold);
    int n = 0;
    @(negedge clk_i);
    while (!blk_valid_o && n < 400) begin
      @(negedge clk_i);
      n++;
    end
    check_eq("blk_valid_wait", 64'(blk_valid_o), 64'd1);
    rx_blk  = blk_o;
    rx_last = blk_last_o;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_i);
      check_eq("hold_blk_stable", 64'(blk_o == rx_blk), 64'd1);
      check_eq("hold_last_stable", 64'(blk_last_o), 64'(rx_last));
      check_eq("hold_valid", 64'(blk_valid_o), 64'd1);
      check_eq("hold_byte_ready", 64'(byte_ready_o), 64'd0);
    end
`ifdef MD5_PAD_LEN_OUT_EN
    if (rx_last) check_eq("msg_bits", msg_bits_o, {rx_blk[15], rx_blk[14]});
`endif
    blk_ready_i = 1'b1;
    @(negedge clk_i);
    blk_ready_i = 1'b0;
  endtask

  task automatic check_words(input string tag, input int lo, input int hi, input word_t exp);
    for (int k = lo; k <= hi; k++) check_eq(tag, 64'(rx_blk[k]), 64'(exp));
  endtask

  initial begin
    rst_i        = 1'b1;
    byte_i       = 8'h00;
    byte_valid_i = 1'b0;
    byte_last_i  = 1'b0;
    byte_empty_i = 1'b0;
    blk_ready_i  = 1'b0;
    repeat (3) @(negedge clk_i);
    check_eq("rst_valid", 64'(blk_valid_o), 64'd0);
    check_eq("rst_last", 64'(blk_last_o), 64'd0);
    check_eq("rst_busy", 64'(busy_o), 64'd0);
    check_eq("rst_blk_zero", 64'(blk_o == '0), 64'd1);
    rst_i = 1'b0;
    @(negedge clk_i);
    check_eq("idle_ready", 64'(byte_ready_o), 64'd1);

    // "abc"
    send_byte(8'h61, 1'b0, 1'b0);
    send_byte(8'h62, 1'b0, 1'b0);
    send_byte(8'h63, 1'b1, 1'b0);
    check_eq("abc_ready_after_last", 64'(byte_ready_o), 64'd0);
    check_eq("abc_busy", 64'(busy_o), 64'd1);
    recv_block(0);
    check_eq("abc_m0", 64'(rx_blk[0]), 64'h8063_6261);
    check_words("abc_m1_13", 1, 13, 32'h0);
    check_eq("abc_m14", 64'(rx_blk[14]), 64'h18);
    check_eq("abc_m15", 64'(rx_blk[15]), 64'h0);
    check_eq("abc_last", 64'(rx_last), 64'd1);
    check_eq("abc_idle_after", 64'(busy_o), 64'd0);
    check_eq("abc_ready_after", 64'(byte_ready_o), 64'd1);

    // Empty message
    send_byte(8'hff, 1'b1, 1'b1);
    recv_block(0);
    check_eq("empty_m0", 64'(rx_blk[0]), 64'h80);
    check_words("empty_m1_15", 1, 15, 32'h0);
    check_eq("empty_last", 64'(rx_last), 64'd1);

    // 55 bytes: 0x80 lands at 55, length fits in the same block
    send_run(55, 8'h61, 1'b1);
    recv_block(0);
    check_words("b55_m0_12", 0, 12, 32'h6161_6161);
    check_eq("b55_m13", 64'(rx_blk[13]), 64'h8061_6161);
    check_eq("b55_m14", 64'(rx_blk[14]), 64'h1b8);
    check_eq("b55_m15", 64'(rx_blk[15]), 64'h0);
    check_eq("b55_last", 64'(rx_last), 64'd1);

    // 56 bytes: length spills into a second block
    send_run(56, 8'h61, 1'b1);
    recv_block(0);
    check_words("b56a_m0_13", 0, 13, 32'h6161_6161);
    check_eq("b56a_m14", 64'(rx_blk[14]), 64'h80);
    check_eq("b56a_m15", 64'(rx_blk[15]), 64'h0);
    check_eq("b56a_last", 64'(rx_last), 64'd0);
    recv_block(0);
    check_words("b56b_m0_13", 0, 13, 32'h0);
    check_eq("b56b_m14", 64'(rx_blk[14]), 64'h1c0);
    check_eq("b56b_m15", 64'(rx_blk[15]), 64'h0);
    check_eq("b56b_last", 64'(rx_last), 64'd1);

    // 64 bytes with back-pressure on the first block
    send_run(64, 8'h61, 1'b1);
    recv_block(5);
    check_words("b64a_m0_15", 0, 15, 32'h6161_6161);
    check_eq("b64a_last", 64'(rx_last), 64'd0);
    recv_block(0);
    check_eq("b64b_m0", 64'(rx_blk[0]), 64'h80);
    check_words("b64b_m1_13", 1, 13, 32'h0);
    check_eq("b64b_m14", 64'(rx_blk[14]), 64'h200);
    check_eq("b64b_m15", 64'(rx_blk[15]), 64'h0);
    check_eq("b64b_last", 64'(rx_last), 64'd1);

    // Reset mid-message discards everything
    send_run(30, 8'h5a, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    check_eq("midrst_valid", 64'(blk_valid_o), 64'd0);
    check_eq("midrst_busy", 64'(busy_o), 64'd0);
    check_eq("midrst_blk_zero", 64'(blk_o == '0), 64'd1);
    @(negedge clk_i);
    rst_i = 1'b0;
    send_byte(8'h61, 1'b0, 1'b0);
    send_byte(8'h62, 1'b0, 1'b0);
    send_byte(8'h63, 1'b1, 1'b0);
    recv_block(0);
    check_eq("abc2_m0", 64'(rx_blk[0]), 64'h8063_6261);
    check_words("abc2_m1_13", 1, 13, 32'h0);
    check_eq("abc2_m14", 64'(rx_blk[14]), 64'h18);
    check_eq("abc2_m15", 64'(rx_blk[15]), 64'h0);
    check_eq("abc2_last", 64'(rx_last), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
